// File: rtl/fpmul_rr_arbiter.sv
// Round-robin sharing of one pipelined fpmul between N_REQ requesters, with tagged result steering.
// Define FPMUL_ARB_FLAGS_EN to return fpmul overflow/underflow flags with each response.
module fpmul_rr_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [15:0]         mul_a,
  output logic [15:0]         mul_b,
  input  logic [15:0]         mul_p,
  input  logic                mul_ovf,
  input  logic                mul_unf,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [15:0]         rsp_p,
  output logic                rsp_ovf,
  output logic                rsp_unf,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned OP_W  = 16;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_lo_idx;
  logic [PTR_W-1:0] w_hi_idx;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_lo_hit;
  logic             w_hi_hit;
  logic             w_hs;
  logic [N_REQ-1:0] w_grant;
  logic [OP_W-1:0]  w_op_a;
  logic [OP_W-1:0]  w_op_b;

  logic [OP_W-1:0]  r_mul_a;
  logic [OP_W-1:0]  r_mul_b;
  logic             r_iss_vld;
  logic [PTR_W-1:0] r_iss_idx;
  logic [MUL_LAT-1:0] r_tag_vld;
  logic [PTR_W-1:0] r_tag_idx [MUL_LAT];
  logic [N_REQ-1:0] r_rsp_valid;
  logic [OP_W-1:0]  r_rsp_p;
  logic             r_busy;

  // Lowest valid index at/after ptr wins; otherwise lowest valid overall (wrap-around).
  always_comb begin
    w_lo_hit = 1'b0;
    w_lo_idx = '0;
    w_hi_hit = 1'b0;
    w_hi_idx = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_hit = 1'b1;
        w_lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= r_ptr) begin
          w_hi_hit = 1'b1;
          w_hi_idx = PTR_W'(i);
        end
      end
    end
  end

  assign w_hs   = w_lo_hit;
  assign w_gidx = w_hi_hit ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_grant = '0;
    w_op_a  = '0;
    w_op_b  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_hs && (w_gidx == PTR_W'(i))) begin
        w_grant[i] = 1'b1;
        w_op_a     = req_a[OP_W*i +: OP_W];
        w_op_b     = req_b[OP_W*i +: OP_W];
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  // Issue stage, tag pipeline aligned with fpmul latency, and response steering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_idx   <= '0;
      r_tag_vld   <= '0;
      for (int k = 0; k < int'(MUL_LAT); k++) r_tag_idx[k] <= '0;
      r_rsp_valid <= '0;
      r_rsp_p     <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_hs) r_ptr <= w_ptr_nxt;
      r_mul_a      <= w_hs ? w_op_a : '0;
      r_mul_b      <= w_hs ? w_op_b : '0;
      r_iss_vld    <= w_hs;
      r_iss_idx    <= w_hs ? w_gidx : '0;
      r_tag_vld[0] <= r_iss_vld;
      r_tag_idx[0] <= r_iss_idx;
      for (int k = 1; k < int'(MUL_LAT); k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
      r_rsp_valid <= r_tag_vld[MUL_LAT-1] ? (N_REQ'(1) << r_tag_idx[MUL_LAT-1]) : '0;
      if (r_tag_vld[MUL_LAT-1]) r_rsp_p <= mul_p;
      r_busy <= w_hs | r_iss_vld | (|r_tag_vld);
    end
  end

`ifdef FPMUL_ARB_FLAGS_EN
  logic r_rsp_ovf;
  logic r_rsp_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_ovf <= 1'b0;
      r_rsp_unf <= 1'b0;
    end else if (r_tag_vld[MUL_LAT-1]) begin
      r_rsp_ovf <= mul_ovf;
      r_rsp_unf <= mul_unf;
    end
  end

  assign rsp_ovf = r_rsp_ovf;
  assign rsp_unf = r_rsp_unf;
`else
  logic w_unused_flags;
  assign w_unused_flags = mul_ovf | mul_unf;
  assign rsp_ovf        = 1'b0;
  assign rsp_unf        = 1'b0;
`endif

  assign req_ready = w_grant;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign busy      = r_busy;

endmodule

// File: doc/fpmul_rr_arbiter.md
# fpmul_rr_arbiter

Shares one fully pipelined `fpmul` half-precision multiplier between `N_REQ` requesters. It uses round-robin arbitration, with one operand pair issued per cycle at most. Each issue is tagged with its requester index in a shift pipeline matched to the multiplier latency. The product and exception flags are steered back to the originating requester. The block sits between the vector/scalar clients and the single `fpmul` instance and owns that instance's operand and result ports.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 3: `fpmul` latency in cycles, from operands at its inputs to `Product`/flags valid. Must be ≥1.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  N_REQ  — per-requester operand valid.
- `req_a`  in  16*N_REQ  — operand A; requester i occupies bits [16i+15:16i].
- `req_b`  in  16*N_REQ  — operand B, same packing.
- `req_ready`  out  N_REQ  — one-hot grant; handshake completes when valid&ready.
- `mul_a`, `mul_b`  out  16  — registered operands to `fpmul` A/B.
- `mul_p`  in  16  — `fpmul` Product.
- `mul_ovf`, `mul_unf`  in  1  — `fpmul` overflow/underflow.
- `rsp_valid`  out  N_REQ  — one-hot, one-cycle pulse; result for requester i.
- `rsp_p`  out  16  — product, valid when any `rsp_valid` bit is set.
- `rsp_ovf`, `rsp_unf`  out  1  — flags accompanying `rsp_p`.
- `busy`  out  1  — high while any issued operation has not yet produced its response.

## Operation

- Arbitration:
  - Round-robin pointer `ptr` is a register of width clog2(N_REQ).
  - Grant goes to the first i with `req_valid[i]`, searching i = ptr, ptr+1, …, wrapping modulo N_REQ.
  - `req_ready` is combinational from `req_valid` and `ptr`. At most one bit is set, and none is set when no valid is present.
- Pointer update: on a handshake with requester g, `ptr` ← (g+1) mod N_REQ. With no handshake, `ptr` holds. Wrap-around from N_REQ-1 goes to 0.
- Requester rule: once `req_valid[i]` is asserted, it and the operands stay stable until the handshake. The block never withdraws `req_ready` from a valid requester except by granting another.
- Issue stage:
  - On a handshake, `mul_a`/`mul_b` register the granted operands, and tag {valid=1, idx=g} enters stage 0 of the tag pipeline.
  - With no handshake, `mul_a`/`mul_b` register 0x0000 and the stage-0 tag valid is 0.
- Tag pipeline: MUL_LAT stages deep, shifting every cycle with no stall. The stage MUL_LAT-1 tag aligns with `mul_p`/flags.
- Response stage: on the edge where the last tag is valid, `rsp_p`, `rsp_ovf`, `rsp_unf` register the `fpmul` outputs and `rsp_valid[idx]` is set for one cycle. Otherwise `rsp_valid` = 0 and `rsp_p`/flags hold their previous values.
- Responses cannot be back-pressured; every requester accepts its pulse.
- Ordering: responses return in issue order. Throughput is one operation per cycle sustained.
- `busy` = OR of all tag valid bits and the issue-stage tag.

## Timing

- Reset (async assert, sync-to-clk deassert handled upstream) sets:
  - `ptr` = 0 and all tag valids = 0;
  - `mul_a` = `mul_b` = 0x0000;
  - `rsp_valid` = 0, `rsp_p` = 0x0000, `rsp_ovf` = `rsp_unf` = 0, `busy` = 0.
  - `req_ready` follows `req_valid` combinationally, even during reset.
- Handshakes while `rst_n` is low are ignored and do not issue.
- Latency: a handshake in cycle 0 produces `rsp_valid` high in cycle MUL_LAT+2. This is cycle 5 at the default.
- Reset asserted mid-flight discards all in-flight operations. No response pulse is ever produced for them.
- Simultaneous valids from all requesters are granted in pointer order, one per cycle, with no requester starved for more than N_REQ-1 cycles.

## Configuration

- `FPMUL_ARB_FLAGS_EN` defined:
  - `rsp_ovf`/`rsp_unf` register `mul_ovf`/`mul_unf` as described above.
- Not defined:
  - the flag registers are omitted and `rsp_ovf`/`rsp_unf` are tied to 0;
  - `mul_ovf`/`mul_unf` are unused.
  - Port list is unchanged.

## Test plan

- Single requester: req 1 presents A=0x4B00, B=0x3600 for one handshake -> `rsp_valid` = 0b0010 exactly in cycle MUL_LAT+2, with `rsp_p` = 0x4540 and flags = 0.
- Contention:
  - all four requesters valid from `ptr` = 0, with operands (0x4B00,0x3600), (0x12AC,0x0000), (0xBC50,0xC438), (0xA600,0x5A00);
  - required: grants 0,1,2,3 on consecutive cycles;
  - required: responses return in order, with req 1 receiving 0x0000; `ptr` ends at 0.
- Fairness: req 0 and req 2 held valid continuously for 8 cycles -> grants alternate 0,2,0,2…; neither waits more than 1 cycle.
- Flags: A=B=0x7970 with the macro defined -> `rsp_ovf` = 1 alongside the response. With the macro undefined -> `rsp_ovf` = 0.
- Back-to-back: req 3 streams 6 operations -> 6 consecutive `rsp_valid[3]` pulses; `busy` falls in the cycle after the last pulse.
- Reset mid-flight: issue 3 operations, then pulse `rst_n` low before the first response -> no `rsp_valid` ever appears for them, and all outputs sit at their reset values.
